// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch control unit and its datapath.
// - Control-word field encodings.
// - Control-word field bit positions.
// - FSM state encoding.
// - A helper that packs four 2-bit fields into the 8-bit control word.
package stopwatch_control_pkg;

  typedef logic [1:0] cw_field_t;

  // Per-counter control encoding, shared with the datapath counters.
  localparam cw_field_t CW_HOLD = 2'b00;
  localparam cw_field_t CW_UP   = 2'b01;
  localparam cw_field_t CW_LOAD = 2'b10;  // never issued by this unit
  localparam cw_field_t CW_CLR  = 2'b11;

  // Field positions inside the 8-bit control word.
  localparam int CW_PRE_LSB    = 0;
  localparam int CW_TENTHS_LSB = 2;
  localparam int CW_UNITS_LSB  = 4;
  localparam int CW_TENS_LSB   = 6;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_FULL = 3'd4
  } state_t;

  function automatic logic [7:0] pack_cw(cw_field_t pre, cw_field_t tenths,
                                         cw_field_t units, cw_field_t tens);
    logic [7:0] w;
    w = '0;
    w[CW_PRE_LSB    +: 2] = pre;
    w[CW_TENTHS_LSB +: 2] = tenths;
    w[CW_UNITS_LSB  +: 2] = units;
    w[CW_TENS_LSB   +: 2] = tens;
    return w;
  endfunction

endpackage

// File: rtl/stopwatch_control_if.sv
// Control/status bundle between the stopwatch control unit and the
// BCD datapath.
// - master (control unit): drives cw, running, full.
//   Receives the datapath status bits tenth, tenthsNine, unitsNine, tensNine.
// - slave (datapath): the reverse directions.
interface stopwatch_control_if;
  logic       tenth;
  logic       tenthsNine;
  logic       unitsNine;
  logic       tensNine;
  logic [7:0] cw;
  logic       running;
  logic       full;

  modport master (
    input  tenth, tenthsNine, unitsNine, tensNine,
    output cw, running, full
  );

  modport slave (
    output tenth, tenthsNine, unitsNine, tensNine,
    input  cw, running, full
  );
endinterface

// File: rtl/stopwatch_control_button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and
// rising-edge press pulse.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   i_btn   raw asynchronous active-high button
//   o_press one-cycle pulse on the debounced rising edge
// The debounced level follows the synchronized input only after the two
// have differed for DB_CNT consecutive cycles. A stable raw press gives the
// pulse DB_CNT+2 cycles later. Release gives no pulse.
module button_conditioner #(
  parameter int DB_CNT = 4,
  parameter int DB_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CNT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;
  logic            w_differ;
  logic            w_flip;

  assign w_differ = r_sync2 ^ r_level;
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= w_flip && !r_level;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt   <= r_cnt + DB_W'(1);
      end else begin
        r_cnt   <= '0;  // any agreement restarts the stability window
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_control.sv
// Control unit for the 3-digit BCD stopwatch.
// - Conditions the start/stop and clear buttons.
// - Runs the CLR/IDLE/RUN/STOP/FULL state machine.
// - Issues the per-counter control word every cycle.
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   btnStartStop  raw start/stop button (active-high)
//   btnClear      raw clear button (active-high)
//   dp            master side of the control/status bundle
// WRAP=0 saturates at 99.9 and enters FULL.
// WRAP=1 rolls over to 00.0 and keeps running.
module stopwatch_control
  import stopwatch_control_pkg::*;
#(
  parameter int DB_CNT = 4,
  parameter int DB_W   = 20,
  parameter int WRAP   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btnStartStop,
  input  logic                btnClear,
  stopwatch_control_if.master dp
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] w_cw;
  logic       w_ss_press;
  logic       w_clr_press;
  logic       w_c1;   // tenths digit rolls this cycle
  logic       w_c2;   // units digit rolls this cycle
  logic       w_tc;   // terminal count 99.9 reached

  button_conditioner #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_bc_ss (
    .clk     (clk),
    .rst_n   (reset),
    .i_btn   (btnStartStop),
    .o_press (w_ss_press)
  );

  button_conditioner #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_bc_clr (
    .clk     (clk),
    .rst_n   (reset),
    .i_btn   (btnClear),
    .o_press (w_clr_press)
  );

  assign w_c1 = dp.tenth & dp.tenthsNine;
  assign w_c2 = w_c1 & dp.unitsNine;
  assign w_tc = w_c2 & dp.tensNine;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_CLR;
    else        r_state <= w_next;
  end

  // NOTE: next state and control word get defaults before the case so that
  // every path assigns them and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_cw   = pack_cw(CW_HOLD, CW_HOLD, CW_HOLD, CW_HOLD);
    case (r_state)
      ST_CLR: begin
        w_cw   = pack_cw(CW_CLR, CW_CLR, CW_CLR, CW_CLR);
        w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_ss_press) w_next = ST_RUN;
      end
      ST_RUN: begin
        w_cw = pack_cw(dp.tenth ? CW_CLR : CW_UP,
                       dp.tenth ? (dp.tenthsNine ? CW_CLR : CW_UP) : CW_HOLD,
                       w_c1 ? (dp.unitsNine ? CW_CLR : CW_UP) : CW_HOLD,
                       (w_c2 && !dp.tensNine) ? CW_UP : CW_HOLD);
        if (w_tc) begin
          if (WRAP != 0) begin
            w_cw = pack_cw(CW_CLR, CW_CLR, CW_CLR, CW_CLR);
          end else begin
            // Digits freeze at 99.9. The prescaler steps once more so it
            // leaves its compare value and does not re-fire.
            w_cw = pack_cw(CW_UP, CW_HOLD, CW_HOLD, CW_HOLD);
          end
        end
        // Saturation outranks a coincident stop so the display never
        // sits in STOP at 99.9 with a stale prescaler.
        if (w_tc && (WRAP == 0)) w_next = ST_FULL;
        else if (w_ss_press)     w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_clr_press)     w_next = ST_CLR;
        else if (w_ss_press) w_next = ST_RUN;
      end
      ST_FULL: begin
        if (w_clr_press) w_next = ST_CLR;
      end
      default: begin
        w_next = ST_CLR;
      end
    endcase
  end

  assign dp.cw      = w_cw;
  assign dp.running = (r_state == ST_RUN);
  assign dp.full    = (r_state == ST_FULL);

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control.
// Two instances share clock, reset and buttons: u_dut0 saturates (WRAP=0)
// and u_dut1 rolls over (WRAP=1). Their status inputs are driven identically.
module tb_stopwatch_control;

  localparam int DB_CNT = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_ss;
  logic btn_clr;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  stopwatch_control_if u_if0 ();
  stopwatch_control_if u_if1 ();

  stopwatch_control #(.DB_CNT(DB_CNT), .DB_W(20), .WRAP(0)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .btnStartStop (btn_ss),
    .btnClear     (btn_clr),
    .dp           (u_if0.master)
  );

  stopwatch_control #(.DB_CNT(DB_CNT), .DB_W(20), .WRAP(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .btnStartStop (btn_ss),
    .btnClear     (btn_clr),
    .dp           (u_if1.master)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Checks cw/running/full on both instances against one expectation.
  task automatic check_both(input string tag, input logic [7:0] cw,
                            input logic run, input logic fl);
    check({tag, " cw0"},   u_if0.cw,      cw);
    check({tag, " cw1"},   u_if1.cw,      cw);
    check({tag, " run0"},  {7'b0, u_if0.running}, {7'b0, run});
    check({tag, " run1"},  {7'b0, u_if1.running}, {7'b0, run});
    check({tag, " full0"}, {7'b0, u_if0.full},    {7'b0, fl});
    check({tag, " full1"}, {7'b0, u_if1.full},    {7'b0, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_status(input logic t, input logic tn, input logic un, input logic tens);
    u_if0.tenth = t; u_if0.tenthsNine = tn; u_if0.unitsNine = un; u_if0.tensNine = tens;
    u_if1.tenth = t; u_if1.tenthsNine = tn; u_if1.unitsNine = un; u_if1.tensNine = tens;
    #1;
  endtask

  // Raises the buttons and stops right after the edge where the press takes
  // effect on the state register (DB_CNT+3 edges).
  task automatic press(input logic ss, input logic clr);
    btn_ss  = ss;
    btn_clr = clr;
    repeat (DB_CNT + 3) tick();
  endtask

  task automatic release_btns();
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    reset   = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    set_status(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for three cycles, then one CLR cycle, then IDLE.
    repeat (3) tick();
    check_both("in_reset", 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_both("clr_after_rel", 8'hFF, 1'b0, 1'b0);
    tick();
    check_both("idle", 8'h00, 1'b0, 1'b0);

    // A two-cycle bounce is shorter than the debounce window.
    btn_ss = 1'b1;
    repeat (2) tick();
    btn_ss = 1'b0;
    repeat (12) tick();
    check_both("bounce", 8'h00, 1'b0, 1'b0);

    // Held press: RUN appears exactly DB_CNT+3 edges after the rise.
    btn_ss = 1'b1;
    repeat (DB_CNT + 2) tick();
    check_both("pre_run", 8'h00, 1'b0, 1'b0);
    tick();
    check_both("run", 8'h01, 1'b1, 1'b0);
    repeat (3) tick();
    release_btns();
    check_both("release_no_pulse", 8'h01, 1'b1, 1'b0);

    // Carry patterns in RUN.
    set_status(1'b1, 1'b0, 1'b0, 1'b0);
    check_both("tenth_only", 8'h07, 1'b1, 1'b0);
    set_status(1'b1, 1'b1, 1'b0, 1'b0);
    check_both("carry_units", 8'h1F, 1'b1, 1'b0);
    set_status(1'b1, 1'b1, 1'b1, 1'b0);
    check_both("carry_tens", 8'h7F, 1'b1, 1'b0);
    set_status(1'b0, 1'b1, 1'b1, 1'b1);
    check_both("nines_no_tenth", 8'h01, 1'b1, 1'b0);

    // Terminal count: saturate vs roll over.
    set_status(1'b1, 1'b1, 1'b1, 1'b1);
    check("tc_cw0", u_if0.cw, 8'h01);
    check("tc_cw1", u_if1.cw, 8'hFF);
    tick();
    set_status(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_cw0",   u_if0.cw, 8'h00);
    check("full_full0", {7'b0, u_if0.full},    8'h01);
    check("full_run0",  {7'b0, u_if0.running}, 8'h00);
    check("wrap_cw1",   u_if1.cw, 8'h01);
    check("wrap_run1",  {7'b0, u_if1.running}, 8'h01);
    check("wrap_full1", {7'b0, u_if1.full},    8'h00);

    // Start/stop is ignored in FULL; the wrapping instance stops.
    press(1'b1, 1'b0);
    release_btns();
    check("full_ss_cw0",   u_if0.cw, 8'h00);
    check("full_ss_full0", {7'b0, u_if0.full},    8'h01);
    check("stop_cw1",      u_if1.cw, 8'h00);
    check("stop_run1",     {7'b0, u_if1.running}, 8'h00);

    // Clear from FULL / STOP: one CLR cycle then IDLE.
    press(1'b0, 1'b1);
    check_both("clr_full", 8'hFF, 1'b0, 1'b0);
    tick();
    check_both("idle_after_clr", 8'h00, 1'b0, 1'b0);
    release_btns();

    // Clear is ignored in IDLE.
    press(1'b0, 1'b1);
    check_both("idle_clr_ign", 8'h00, 1'b0, 1'b0);
    release_btns();

    // IDLE -> RUN -> STOP, then both buttons at once: clear wins.
    press(1'b1, 1'b0);
    check_both("run2", 8'h01, 1'b1, 1'b0);
    release_btns();
    press(1'b1, 1'b0);
    check_both("stop2", 8'h00, 1'b0, 1'b0);
    release_btns();
    press(1'b1, 1'b1);
    check_both("both_clr", 8'hFF, 1'b0, 1'b0);
    tick();
    check_both("both_idle", 8'h00, 1'b0, 1'b0);
    release_btns();

    // Asynchronous reset mid-RUN, away from any clock edge.
    press(1'b1, 1'b0);
    release_btns();
    check_both("run3", 8'h01, 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_both("async_rst", 8'hFF, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_both("idle_after_rst", 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
